// File: rtl/fetch_inst_queue.sv
// Fetch-to-decode instruction queue: two-wide compacting writes from the
// branch-prediction filter stage, up to two in-order pops per cycle by decode.
package fetch_inst_queue_pkg;
  typedef struct packed {
    logic        taken;
    logic [1:0]  btype;
    logic [31:0] target;
  } bpu_predict_t;
endpackage

module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [1:0]              valid_i,
  input  logic [1:0][31:0]        pc_i,
  input  logic [1:0][31:0]        inst_i,
  input  bpu_predict_t [1:0]      predict_i,
  output logic                    fifo_ready_o,
  output logic [1:0]              valid_o,
  output logic [1:0][31:0]        pc_o,
  output logic [1:0][31:0]        inst_o,
  output bpu_predict_t [1:0]      predict_o,
  input  logic [1:0]              issue_num_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Storage is never reset; valid_o alone qualifies the payload.
  logic [31:0]  pc_mem   [DEPTH];
  logic [31:0]  inst_mem [DEPTH];
  bpu_predict_t pred_mem [DEPTH];

  logic          wr_en;
  logic          we0, we1;
  logic [PW-1:0] widx0, widx1;
  logic [1:0]    wr_num;
  logic [1:0]    iss_clamp;
  logic [1:0]    pop_num;
  logic [PW-1:0] head_p1;

  // Readiness deliberately ignores same-cycle pops to keep it a pure register decode.
  assign fifo_ready_o = (count_q <= CW'(DEPTH - 2));
  assign wr_en        = fifo_ready_o & ~flush_i & (|valid_i);
  assign we0          = wr_en & valid_i[0];
  assign we1          = wr_en & valid_i[1];
  assign widx0        = tail_q;
  assign widx1        = valid_i[0] ? (tail_q + PW'(1)) : tail_q;

  always_comb begin
    wr_num    = 2'd0;
    iss_clamp = issue_num_i;
    pop_num   = 2'd0;
    if (wr_en) begin
      wr_num = (valid_i == 2'b11) ? 2'd2 : 2'd1;
    end
    if (issue_num_i == 2'd3) begin
      iss_clamp = 2'd2;
    end
    if (count_q < {{(CW-2){1'b0}}, iss_clamp}) begin
      pop_num = count_q[1:0];
    end else begin
      pop_num = iss_clamp;
    end
  end

  always_comb begin
    head_d  = head_q + PW'(pop_num);
    tail_d  = tail_q + PW'(wr_num);
    count_d = count_q + CW'(wr_num) - CW'(pop_num);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) begin
      pc_mem[widx0]   <= pc_i[0];
      inst_mem[widx0] <= inst_i[0];
      pred_mem[widx0] <= predict_i[0];
    end
    if (we1) begin
      pc_mem[widx1]   <= pc_i[1];
      inst_mem[widx1] <= inst_i[1];
      pred_mem[widx1] <= predict_i[1];
    end
  end

  // Read straight from the array: a freshly written entry appears next cycle.
  assign head_p1      = head_q + PW'(1);
  assign valid_o[0]   = (count_q >= CW'(1));
  assign valid_o[1]   = (count_q >= CW'(2));
  assign pc_o[0]      = pc_mem[head_q];
  assign pc_o[1]      = pc_mem[head_p1];
  assign inst_o[0]    = inst_mem[head_q];
  assign inst_o[1]    = inst_mem[head_p1];
  assign predict_o[0] = pred_mem[head_q];
  assign predict_o[1] = pred_mem[head_p1];

endmodule
